// File: rtl/mem_arbiter_if.sv
// Bus bundle joining fetch, data path and the single memory port to mem_arbiter.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_arbiter_if #(
  parameter int RV = 32,
  parameter int VA = 24
);
  logic          i_req;
  logic [VA-1:0] i_addr;
  logic          i_done;
  logic [15:0]   i_rdata;

  logic          d_req;
  logic          d_write;
  logic          d_byte;
  logic          d_io;
  logic [VA-1:0] d_addr;
  logic [RV-1:0] d_wdata;
  logic          d_done;
  logic [RV-1:0] d_rdata;

  logic          m_req;
  logic          m_write;
  logic          m_byte;
  logic          m_io;
  logic [VA-1:0] m_addr;
  logic [RV-1:0] m_wdata;
  logic          m_ack;
  logic          m_done;
  logic [RV-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_write, d_byte, d_io, d_addr, d_wdata,
    input  m_ack, m_done, m_rdata,
    output i_done, i_rdata, d_done, d_rdata,
    output m_req, m_write, m_byte, m_io, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_write, d_byte, d_io, d_addr, d_wdata,
    output m_ack, m_done, m_rdata,
    input  i_done, i_rdata, d_done, d_rdata,
    input  m_req, m_write, m_byte, m_io, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the data path, one access in flight.
// Data wins ties unless fetch has already been passed over STARVE times in a row.
//
// state | meaning
// IDLE  | no access in flight; arbitrate between i_req and d_req
// ISSUE | m_req high with winner's fields, waiting for m_ack
// WAIT  | request accepted, waiting for m_done
// RESP  | owner's done pulse is high with captured read data
module mem_arbiter #(
  parameter int RV     = 32,
  parameter int VA     = 24,
  parameter int STARVE = 3
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state;
  logic          owner_data;
  logic [SW-1:0] starve;
  logic          grant_data;
  logic          resp_now;
  logic [15:0]   fetch_half;

  assign grant_data = bus.d_req && !(bus.i_req && (starve == STARVE_MAX));
  assign resp_now   = ((state == ISSUE) && bus.m_ack && bus.m_done) ||
                      ((state == WAIT) && bus.m_done);

  // m_addr still holds the fetch address when the response comes back.
  generate
    if (RV == 32) begin : g_rv32
      assign fetch_half = bus.m_addr[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
    end else begin : g_rv16
      assign fetch_half = bus.m_rdata[15:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      owner_data  <= 1'b0;
      starve      <= '0;
      bus.i_done  <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_done  <= 1'b0;
      bus.d_rdata <= '0;
      bus.m_req   <= 1'b0;
      bus.m_write <= 1'b0;
      bus.m_byte  <= 1'b0;
      bus.m_io    <= 1'b0;
      bus.m_addr  <= '0;
      bus.m_wdata <= '0;
    end else begin
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!bus.i_req) starve <= '0;
          if (grant_data) begin
            owner_data  <= 1'b1;
            bus.m_req   <= 1'b1;
            bus.m_write <= bus.d_write;
            bus.m_byte  <= bus.d_byte;
            bus.m_io    <= bus.d_io;
            bus.m_addr  <= bus.d_addr;
            bus.m_wdata <= bus.d_wdata;
            if (bus.i_req && (starve != STARVE_MAX)) starve <= starve + 1'b1;
            state <= ISSUE;
          end else if (bus.i_req) begin
            owner_data  <= 1'b0;
            bus.m_req   <= 1'b1;
            bus.m_write <= 1'b0;
            bus.m_byte  <= 1'b0;
            bus.m_io    <= 1'b0;
            bus.m_addr  <= bus.i_addr;
            bus.m_wdata <= '0;
            starve      <= '0;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.m_ack) begin
            bus.m_req <= 1'b0;
            state     <= bus.m_done ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (bus.m_done) state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (resp_now) begin
        if (owner_data) begin
          bus.d_done  <= 1'b1;
          bus.d_rdata <= bus.m_rdata;
        end else begin
          bus.i_done  <= 1'b1;
          bus.i_rdata <= fetch_half;
        end
      end
    end
  end
endmodule
